prod_accum: RTL and testbench

PROD_ACCUM -- requirements
Module: prod_accum

---
 rtl/prod_accum_pkg.sv | 18 +
 rtl/acc_sat_add.sv | 31 +++
 rtl/prod_accum.sv | 113 +++++++++++
 tb/tb_prod_accum.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/prod_accum_pkg.sv
// Shared types and constants for the product accumulator.
// Holds the FSM encoding, port widths and the full-adder cell.
package prod_accum_pkg;

  localparam int P_W   = 8;
  localparam int CNT_W = 4;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] fa(input logic a, input logic b, input logic ci);
    fa = {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
  endfunction

endpackage

// File: rtl/acc_sat_add.sv
// Combinational ripple-carry add of an 8-bit product onto the accumulator,
// evaluated at ACC_W+1 bits and clamped to the all-ones ACC_W value.
module acc_sat_add
  import prod_accum_pkg::*;
#(
  parameter int ACC_W = 10
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [P_W-1:0]   prod_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             sat_o
);

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W:0]   carry;
  logic [ACC_W:0]   raw;

  assign prod_ext = {{(ACC_W - P_W){1'b0}}, prod_i};
  assign carry[0] = 1'b0;

  for (genvar i = 0; i < ACC_W; i++) begin : g_fa
    assign {carry[i+1], raw[i]} = fa(acc_i[i], prod_ext[i], carry[i]);
  end

  // Both operands are zero in the top bit, so that cell's sum is the carry in.
  assign raw[ACC_W] = carry[ACC_W];

  assign sat_o = raw[ACC_W];
  assign sum_o = sat_o ? {ACC_W{1'b1}} : raw[ACC_W-1:0];

endmodule

// File: rtl/prod_accum.sv
// Sums N_TERMS unsigned products into a saturating accumulator, then holds
// the result under a valid/ready handshake until it is taken or aborted.
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int ACC_W   = 10,
  parameter int N_TERMS = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [P_W-1:0]   P,
  input  logic             P_VALID,
  output logic             P_READY,
  input  logic             CLR,
  output logic [ACC_W-1:0] R,
  output logic             R_VALID,
  input  logic             R_READY,
  output logic             OVF,
  output logic [CNT_W-1:0] CNT
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             consume;
  logic [ACC_W-1:0] sum;
  logic             sat;

  assign accept  = (state_q == ACC)  && P_VALID && !CLR;
  assign consume = (state_q == HOLD) && R_READY && !CLR;

  acc_sat_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .acc_i  (acc_q),
    .prod_i (P),
    .sum_o  (sum),
    .sat_o  (sat)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values; combinational blocks use blocking ones.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ACC;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path
  // through the block leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    if (CLR) begin
      state_d = ACC;
    end else begin
      case (state_q)
        ACC:     if (accept && (cnt_q == LAST_CNT)) state_d = HOLD;
        HOLD:    if (R_READY) state_d = ACC;
        default: state_d = ACC;
      endcase
    end
  end

  always_comb begin
    P_READY = 1'b0;
    R_VALID = 1'b0;
    case (state_q)
      ACC:     P_READY = 1'b1;
      HOLD:    R_VALID = 1'b1;
      default: P_READY = 1'b1;
    endcase
  end

  // Abort and result hand-off both restart the sum from zero.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (CLR || consume) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (accept) begin
      acc_d = sum;
      cnt_d = cnt_q + CNT_W'(1);
      ovf_d = ovf_q | sat;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign R   = acc_q;
  assign OVF = ovf_q;
  assign CNT = cnt_q;

endmodule

// File: tb/tb_prod_accum.sv
// Bench for prod_accum: a sum/count model checked every cycle, directed
// scenarios with hand-computed values, and an N_TERMS = 1 instance.
module tb_prod_accum;

  localparam int ACC_W = 10;
  localparam int N     = 8;
  localparam int MAXV  = 1023;

  logic CLK   = 1'b0;
  logic RST_N = 1'b1;
  always #5 CLK = ~CLK;

  logic [7:0]       p;
  logic             p_valid, clr, r_ready;
  logic             p_ready, r_valid, ovf;
  logic [ACC_W-1:0] r;
  logic [3:0]       cnt;

  logic [7:0]       b_p;
  logic             b_pv, b_clr, b_rr;
  logic             b_pready, b_rv, b_ovf;
  logic [ACC_W-1:0] b_r;
  logic [3:0]       b_cnt;

  prod_accum #(.ACC_W(ACC_W), .N_TERMS(N)) dut (
    .CLK(CLK), .RST_N(RST_N), .P(p), .P_VALID(p_valid), .P_READY(p_ready),
    .CLR(clr), .R(r), .R_VALID(r_valid), .R_READY(r_ready), .OVF(ovf), .CNT(cnt)
  );

  prod_accum #(.ACC_W(ACC_W), .N_TERMS(1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .P(b_p), .P_VALID(b_pv), .P_READY(b_pready),
    .CLR(b_clr), .R(b_r), .R_VALID(b_rv), .R_READY(b_rr), .OVF(b_ovf), .CNT(b_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: running total of accepted products and how many were taken.
  int m_total = 0;
  int m_cnt   = 0;
  bit m_chk_en = 1'b0;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_total = 0;
      m_cnt   = 0;
    end else if (clr) begin
      m_total = 0;
      m_cnt   = 0;
    end else if (m_cnt == N) begin
      if (r_ready) begin
        m_total = 0;
        m_cnt   = 0;
      end
    end else if (p_valid) begin
      m_total = m_total + int'(p);
      m_cnt   = m_cnt + 1;
    end
  end

  always @(negedge CLK) begin
    if (RST_N && m_chk_en) begin
      check("model_R",       32'(r),       32'((m_total > MAXV) ? MAXV : m_total));
      check("model_OVF",     32'(ovf),     32'(m_total > MAXV));
      check("model_CNT",     32'(cnt),     32'(m_cnt));
      check("model_R_VALID", 32'(r_valid), 32'(m_cnt == N));
      check("model_P_READY", 32'(p_ready), 32'(m_cnt != N));
    end
  end

  task automatic step(input logic pv, input logic [7:0] pp, input logic c, input logic rr);
    p_valid = pv;
    p       = pp;
    clr     = c;
    r_ready = rr;
    @(posedge CLK);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    p = 8'd0; p_valid = 1'b0; clr = 1'b0; r_ready = 1'b0;
    b_p = 8'd0; b_pv = 1'b0; b_clr = 1'b0; b_rr = 1'b0;

    #1 RST_N = 1'b0;
    #2;
    check("rst_R",       32'(r),       32'd0);
    check("rst_R_VALID", 32'(r_valid), 32'd0);
    check("rst_P_READY", 32'(p_ready), 32'd1);
    check("rst_CNT",     32'(cnt),     32'd0);
    check("rst_OVF",     32'(ovf),     32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    m_chk_en = 1'b1;
    @(posedge CLK);
    #2;

    // Eight products of 0x10.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'h10, 1'b0, 1'b0);
      if (i == 6) check("x10_rv_before_last", 32'(r_valid), 32'd0);
    end
    check("x10_R",       32'(r),       32'd128);
    check("x10_R_VALID", 32'(r_valid), 32'd1);
    check("x10_CNT",     32'(cnt),     32'd8);
    check("x10_OVF",     32'(ovf),     32'd0);
    step(1'b0, 8'd0, 1'b0, 1'b1);
    check("x10_taken_RV",  32'(r_valid), 32'd0);
    check("x10_taken_CNT", 32'(cnt),     32'd0);

    // Eight products of 225: saturates on the fifth.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'd225, 1'b0, 1'b0);
      if (i == 3) begin
        check("sat4_R",   32'(r),   32'd900);
        check("sat4_OVF", 32'(ovf), 32'd0);
      end
      if (i == 4) begin
        check("sat5_R",   32'(r),   32'd1023);
        check("sat5_OVF", 32'(ovf), 32'd1);
      end
    end
    check("sat8_R",       32'(r),       32'd1023);
    check("sat8_OVF",     32'(ovf),     32'd1);
    check("sat8_R_VALID", 32'(r_valid), 32'd1);

    // Back-pressure: products offered while the result is held.
    repeat (5) step(1'b1, 8'd7, 1'b0, 1'b0);
    check("hold_R",       32'(r),       32'd1023);
    check("hold_P_READY", 32'(p_ready), 32'd0);
    check("hold_CNT",     32'(cnt),     32'd8);
    step(1'b1, 8'd7, 1'b0, 1'b1);
    check("hold_taken_CNT", 32'(cnt),     32'd0);
    check("hold_taken_RV",  32'(r_valid), 32'd0);
    check("hold_taken_OVF", 32'(ovf),     32'd0);
    step(1'b1, 8'd7, 1'b0, 1'b0);
    check("after_hold_R",   32'(r),   32'd7);
    check("after_hold_CNT", 32'(cnt), 32'd1);

    // Abort mid-sum; concurrent product is dropped.
    step(1'b0, 8'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'd50, 1'b0, 1'b0);
    check("clr_pre_R", 32'(r), 32'd150);
    step(1'b1, 8'd9, 1'b1, 1'b0);
    check("clr_R",   32'(r),   32'd0);
    check("clr_CNT", 32'(cnt), 32'd0);
    for (int i = 0; i < 8; i++) step(1'b1, 8'd1, 1'b0, 1'b0);
    check("clr_after_R",  32'(r),       32'd8);
    check("clr_after_RV", 32'(r_valid), 32'd1);
    step(1'b1, 8'd5, 1'b1, 1'b1);
    check("clr_hold_RV", 32'(r_valid), 32'd0);
    check("clr_hold_R",  32'(r),       32'd0);

    // Zero products count; then an asynchronous reset mid-cycle.
    step(1'b1, 8'd0, 1'b0, 1'b0);
    step(1'b1, 8'd3, 1'b0, 1'b0);
    step(1'b1, 8'd0, 1'b0, 1'b0);
    step(1'b1, 8'd3, 1'b0, 1'b0);
    check("zero_CNT", 32'(cnt), 32'd4);
    check("zero_R",   32'(r),   32'd6);
    p_valid = 1'b0;
    #1 RST_N = 1'b0;
    #1;
    check("arst_CNT",     32'(cnt),     32'd0);
    check("arst_R",       32'(r),       32'd0);
    check("arst_P_READY", 32'(p_ready), 32'd1);
    #3 RST_N = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        step(1'b0, 8'd2, 1'b0, 1'b0);
        step(1'b0, 8'd2, 1'b0, 1'b0);
        check("idle_CNT", 32'(cnt), 32'd4);
      end
      step(1'b1, 8'd2, 1'b0, 1'b0);
    end
    check("arst_after_R",  32'(r),       32'd16);
    check("arst_after_RV", 32'(r_valid), 32'd1);
    step(1'b0, 8'd0, 1'b0, 1'b1);

    // Single-term instance with the result always taken.
    check("n1_idle_RV", 32'(b_rv), 32'd0);
    b_pv = 1'b1;
    b_p  = 8'd200;
    b_rr = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge CLK);
      #2;
      check("n1_R_VALID", 32'(b_rv),     32'((k % 2) == 0));
      check("n1_R",       32'(b_r),      ((k % 2) == 0) ? 32'd200 : 32'd0);
      check("n1_P_READY", 32'(b_pready), 32'((k % 2) == 1));
    end

    m_chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
